sram_bank_arbiter: RTL and testbench

- Shares the on-chip SRAM banks between two requesters: the CPU port and the host/loader port driven from Wishbone.
- Each bank is a pair of 512x8 macros forming one 16-bit word.
- Sequences each access as a fixed 4-state transaction on the macros' synchronous interface, with active-low CEN/GWEN.
- Returns read data and a one-cycle ack to the granted requester.

---
 rtl/sram_bank_arbiter.sv | 175 +++++++++++++++++
 tb/tb_sram_bank_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bank_arbiter.sv
// rtl/sram_bank_arbiter.sv - two-requester round-robin arbiter sequencing 4-state SRAM bank accesses
module sram_bank_arbiter #(
    parameter int NBANKS  = 4,
    parameter int BANK_AW = 9,
    parameter int DW      = 16,
    parameter int CPU_AW  = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [CPU_AW-1:0]    cpu_addr,
    input  logic [DW-1:0]        cpu_wdata,
    output logic [DW-1:0]        cpu_rdata,
    output logic                 cpu_ack,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [CPU_AW-1:0]    host_addr,
    input  logic [DW-1:0]        host_wdata,
    output logic [DW-1:0]        host_rdata,
    output logic                 host_ack,
    input  logic                 host_excl,
    output logic [BANK_AW-1:0]   mem_addr,
    output logic [DW-1:0]        mem_wdata,
    output logic [NBANKS-1:0]    mem_cenb,
    output logic                 mem_gwenb,
    input  logic [NBANKS*DW-1:0] mem_q,
    output logic                 busy
);
    localparam int BW = $clog2(NBANKS);
    localparam int HI = BANK_AW + BW;

    typedef enum logic [1:0] {S_IDLE, S_MEM, S_WAIT, S_ACK} state_t;
    localparam logic OWN_CPU  = 1'b0;
    localparam logic OWN_HOST = 1'b1;

    state_t              state_q, state_d;
    logic                owner_q, owner_d;
    logic                last_grant_q, last_grant_d;
    logic                we_q, we_d;
    logic                oor_q, oor_d;
    logic [BW-1:0]       bank_q, bank_d;
    logic [BANK_AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]       mem_wdata_q, mem_wdata_d;
    logic [NBANKS-1:0]   mem_cenb_q, mem_cenb_d;
    logic                mem_gwenb_q, mem_gwenb_d;
    logic [DW-1:0]       cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0]       host_rdata_q, host_rdata_d;
    logic                cpu_ack_q, cpu_ack_d;
    logic                host_ack_q, host_ack_d;
    logic                busy_q, busy_d;

    logic                cpu_elig;
    logic                pick_host;
    logic [CPU_AW-1:0]   sel_addr;
    logic                sel_we;
    logic [DW-1:0]       sel_wdata;
    logic                sel_oor;
    logic [BW-1:0]       sel_bank;
    logic [DW-1:0]       rd_word;

    // Next-state and registered-output computation; macro controls are precomputed so they are flop outputs
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        oor_d        = oor_q;
        bank_d       = bank_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_cenb_d   = '1;
        mem_gwenb_d  = 1'b1;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
        cpu_ack_d    = 1'b0;
        host_ack_d   = 1'b0;

        cpu_elig  = cpu_req & ~host_excl;
        pick_host = host_req & (~cpu_elig | (last_grant_q == OWN_CPU));
        sel_addr  = pick_host ? host_addr  : cpu_addr;
        sel_we    = pick_host ? host_we    : cpu_we;
        sel_wdata = pick_host ? host_wdata : cpu_wdata;
        sel_oor   = |sel_addr[CPU_AW-1:HI];
        sel_bank  = sel_addr[HI-1:BANK_AW];
        rd_word   = mem_q[int'(bank_q)*DW +: DW];

        case (state_q)
            S_IDLE: begin
                if (cpu_elig | host_req) begin
                    owner_d      = pick_host;
                    last_grant_d = pick_host;
                    we_d         = sel_we;
                    oor_d        = sel_oor;
                    bank_d       = sel_bank;
                    mem_addr_d   = sel_addr[BANK_AW-1:0];
                    mem_wdata_d  = sel_wdata;
                    if (!sel_oor) begin
                        mem_cenb_d[sel_bank] = 1'b0;
                        mem_gwenb_d          = ~sel_we;
                    end
                    state_d = S_MEM;
                end
            end
            S_MEM: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (owner_q == OWN_HOST) begin
                    host_rdata_d = (we_q | oor_q) ? '0 : rd_word;
                    host_ack_d   = 1'b1;
                end else begin
                    cpu_rdata_d  = (we_q | oor_q) ? '0 : rd_word;
                    cpu_ack_d    = 1'b1;
                end
                state_d = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset abandons any in-flight access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_HOST;
            we_q         <= 1'b0;
            oor_q        <= 1'b0;
            bank_q       <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_cenb_q   <= '1;
            mem_gwenb_q  <= 1'b1;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
            cpu_ack_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            oor_q        <= oor_d;
            bank_q       <= bank_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_cenb_q   <= mem_cenb_d;
            mem_gwenb_q  <= mem_gwenb_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
            cpu_ack_q    <= cpu_ack_d;
            host_ack_q   <= host_ack_d;
            busy_q       <= busy_d;
        end
    end

    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_cenb   = mem_cenb_q;
    assign mem_gwenb  = mem_gwenb_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign host_rdata = host_rdata_q;
    assign cpu_ack    = cpu_ack_q;
    assign host_ack   = host_ack_q;
    assign busy       = busy_q;
endmodule

// File: tb/tb_sram_bank_arbiter.sv
// tb/tb_sram_bank_arbiter.sv - self-checking bench for sram_bank_arbiter with transaction-level model
module tb_sram_bank_arbiter;
    logic        clk;
    logic        rst;
    logic        cpu_req, cpu_we, host_req, host_we, host_excl;
    logic [11:0] cpu_addr, host_addr;
    logic [15:0] cpu_wdata, host_wdata, cpu_rdata, host_rdata, mem_wdata;
    logic        cpu_ack, host_ack, mem_gwenb, busy;
    logic [8:0]  mem_addr;
    logic [3:0]  mem_cenb;
    logic [63:0] mem_q;

    int errors = 0;
    int checks = 0;
    bit started = 0;

    sram_bank_arbiter dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rdata(host_rdata), .host_ack(host_ack), .host_excl(host_excl),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_cenb(mem_cenb), .mem_gwenb(mem_gwenb),
        .mem_q(mem_q), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] pat(input int a);
        return 16'((a * 37) ^ 16'h5A5A);
    endfunction

    // SRAM macro models: synchronous read/write, q updates on an enabled read edge
    logic [15:0] smem [4][512];
    initial begin
        for (int b = 0; b < 4; b++)
            for (int w = 0; w < 512; w++)
                smem[b][w] = pat(b * 512 + w);
        mem_q = '0;
    end
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!mem_cenb[b]) begin
                if (!mem_gwenb) smem[b][mem_addr] = mem_wdata;
                else            mem_q[b*16 +: 16] <= smem[b][mem_addr];
            end
        end
    end

    // Reference model: one transaction at a time, tracked by its age since the grant edge
    logic [15:0] refmem [2048];
    initial for (int a = 0; a < 2048; a++) refmem[a] = pat(a);
    bit          grant_log [$];
    int          age;
    bit          last_host, cur_host, cur_we;
    int          cur_addr;
    logic [3:0]  e_cenb;
    logic        e_gwenb, e_cack, e_hack, e_busy;
    logic [8:0]  e_addr;
    logic [15:0] e_wdata, e_crd, e_hrd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            age = 0; last_host = 1;
            e_cenb = 4'hF; e_gwenb = 1; e_addr = 0; e_wdata = 0;
            e_cack = 0; e_hack = 0; e_crd = 0; e_hrd = 0; e_busy = 0;
        end else begin
            bit c_el, t_host;
            logic [15:0] rd, t_wdata;
            e_cack = 0; e_hack = 0; e_cenb = 4'hF; e_gwenb = 1;
            if (age == 0) begin
                c_el = cpu_req && !host_excl;
                if (c_el || host_req) begin
                    if (c_el && host_req) t_host = !last_host;
                    else                  t_host = host_req;
                    last_host = t_host;
                    grant_log.push_back(t_host);
                    cur_host = t_host;
                    cur_we   = t_host ? host_we : cpu_we;
                    cur_addr = t_host ? int'(host_addr) : int'(cpu_addr);
                    t_wdata  = t_host ? host_wdata : cpu_wdata;
                    e_addr   = 9'(cur_addr % 512);
                    e_wdata  = t_wdata;
                    if (cur_addr < 2048) begin
                        e_cenb  = 4'hF & ~(4'b0001 << (cur_addr / 512));
                        e_gwenb = !cur_we;
                        if (cur_we) refmem[cur_addr] = t_wdata;
                    end
                    age = 1;
                end
            end else if (age == 1) begin
                age = 2;
            end else if (age == 2) begin
                rd = (cur_we || cur_addr >= 2048) ? 16'h0 : refmem[cur_addr];
                if (cur_host) begin e_hrd = rd; e_hack = 1; end
                else          begin e_crd = rd; e_cack = 1; end
                age = 3;
            end else begin
                age = 0;
            end
            e_busy = (age != 0);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (started) begin
            chk("cenb", 32'(mem_cenb), 32'(e_cenb));
            chk("gwenb", 32'(mem_gwenb), 32'(e_gwenb));
            chk("cpu_ack", 32'(cpu_ack), 32'(e_cack));
            chk("host_ack", 32'(host_ack), 32'(e_hack));
            chk("cpu_rdata", 32'(cpu_rdata), 32'(e_crd));
            chk("host_rdata", 32'(host_rdata), 32'(e_hrd));
            chk("busy", 32'(busy), 32'(e_busy));
            if (rst || e_cenb != 4'hF) begin
                chk("mem_addr", 32'(mem_addr), 32'(e_addr));
                chk("mem_wdata", 32'(mem_wdata), 32'(e_wdata));
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        tick(); tick();
        rst = 0;
    endtask

    initial begin
        int cack_n, hack_n;
        logic [15:0] seq;
        rst = 0; cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0; host_excl = 0;
        #3 rst = 1;
        started = 1;
        tick(); tick();
        rst = 0;
        chk("rst_cenb", 32'(mem_cenb), 32'hF);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rdata", 32'({cpu_rdata, host_rdata}), 32'h0);
        tick();

        // CPU write then read back at bank 2 word 5
        cpu_req = 1; cpu_we = 1; cpu_addr = 12'h405; cpu_wdata = 16'hBEEF;
        tick();
        chk("wr_cenb", 32'(mem_cenb), 32'b1011);
        chk("wr_gwenb", 32'(mem_gwenb), 32'h0);
        chk("wr_addr", 32'(mem_addr), 32'h005);
        chk("wr_wdata", 32'(mem_wdata), 32'hBEEF);
        cpu_req = 0; cpu_addr = 12'h000;
        tick(); tick();
        chk("wr_ack", 32'(cpu_ack), 32'h1);
        tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h405;
        tick();
        chk("rd_gwenb", 32'(mem_gwenb), 32'h1);
        cpu_req = 0;
        tick(); tick();
        chk("rd_ack", 32'(cpu_ack), 32'h1);
        chk("rd_data", 32'(cpu_rdata), 32'hBEEF);
        tick();

        // Simultaneous requests from reset: CPU first, then alternate
        do_reset();
        grant_log.delete();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h010;
        host_req = 1; host_we = 0; host_addr = 12'h610;
        repeat (16) tick();
        cpu_req = 0; host_req = 0;
        chk("rr_count", 32'(grant_log.size()), 32'd4);
        if (grant_log.size() == 4)
            chk("rr_order", 32'({grant_log[0], grant_log[1], grant_log[2], grant_log[3]}), 32'b0101);
        repeat (4) tick();

        // Host exclusive: only host granted, then CPU wins at the next idle
        grant_log.delete();
        host_excl = 1; cpu_req = 1; host_req = 1; host_addr = 12'h1F0; cpu_addr = 12'h0F0;
        cack_n = 0; hack_n = 0;
        repeat (20) begin
            tick();
            cack_n += int'(cpu_ack);
            hack_n += int'(host_ack);
        end
        chk("excl_host_acks", 32'(hack_n), 32'd5);
        chk("excl_cpu_acks", 32'(cack_n), 32'd0);
        host_excl = 0; host_req = 0;
        tick();
        chk("excl_release_n", 32'(grant_log.size()), 32'd6);
        if (grant_log.size() == 6)
            chk("excl_release_cpu", 32'(grant_log[5]), 32'd0);
        cpu_req = 0;
        repeat (4) tick();

        // Out-of-range CPU read
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h800;
        tick();
        chk("oor_cenb_mem", 32'(mem_cenb), 32'hF);
        cpu_req = 0;
        tick();
        chk("oor_cenb_wait", 32'(mem_cenb), 32'hF);
        tick();
        chk("oor_ack", 32'(cpu_ack), 32'h1);
        chk("oor_rdata", 32'(cpu_rdata), 32'h0);
        tick();

        // Reset during the WAIT of a host read
        host_req = 1; host_we = 0; host_addr = 12'h205;
        tick(); tick();
        cpu_req = 1; cpu_we = 0; cpu_addr = 12'h003;
        rst = 1;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_cenb", 32'(mem_cenb), 32'hF);
        chk("arst_hrdata", 32'(host_rdata), 32'h0);
        tick();
        chk("arst_hack", 32'(host_ack), 32'h0);
        rst = 0;
        grant_log.delete();
        tick();
        chk("arst_first_n", 32'(grant_log.size()), 32'd1);
        if (grant_log.size() == 1)
            chk("arst_first_cpu", 32'(grant_log[0]), 32'd0);
        cpu_req = 0; host_req = 0;
        repeat (4) tick();

        // Back-to-back host writes walking the banks
        host_req = 1; host_we = 1;
        seq = 16'h0;
        for (int k = 0; k < 4; k++) begin
            host_addr = 12'((k << 9) | 7);
            host_wdata = 16'($urandom);
            tick();
            seq = {seq[11:0], mem_cenb};
            if (k == 3) host_req = 0;
            tick();
            chk("b2b_busy", 32'(busy), 32'h1);
            tick(); tick();
        end
        chk("b2b_cenb_walk", 32'(seq), 32'hEDB7);
        chk("b2b_idle", 32'(busy), 32'h0);

        // Randomized traffic against the model
        repeat (600) begin
            cpu_req = ($urandom % 4) != 0;
            host_req = ($urandom % 3) != 0;
            host_excl = ($urandom % 8) == 0;
            cpu_we = $urandom % 2;
            host_we = $urandom % 2;
            cpu_addr = 12'($urandom);
            host_addr = 12'($urandom);
            cpu_wdata = 16'($urandom);
            host_wdata = 16'($urandom);
            tick();
        end
        cpu_req = 0; host_req = 0; host_excl = 0;
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
